fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the RISC-V core. It sits directly upstream of the opcode decoder/control unit. It owns the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses. Fetched words are buffered in a small FIFO and presented to decode with their PC and opcode field. A redirect from branch resolution (BEQ taken) flushes buffered and in-flight fetches.

Parameters:
XLEN, 32, width of PC and instruction memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction FIFO entries; also the maximum of (outstanding requests + FIFO occupancy)

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  reset, asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts the request this cycle
imem_req_addr  output  XLEN  fetch address; equals the current PC, bits [1:0] always 0
imem_resp_valid  input  1  response word valid; responses return in order, at least 1 cycle after acceptance
imem_resp_data  input  32  response instruction word
id_valid  output  1  FIFO head is valid toward decode
id_ready  input  1  decode consumes the head this cycle
id_instr  output  32  FIFO head instruction
id_pc  output  XLEN  PC of the FIFO head
id_opcode  output  7  id_instr[6:0]; drives the control unit opcode input
redirect_valid  input  1  branch taken; flush and refetch
redirect_pc  input  XLEN  new PC; bits [1:0] are ignored and forced to 0

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; outstanding=0; drop=0; FIFO empty.
  - imem_req_valid=0, id_valid=0; id_instr/id_pc/id_opcode=0.
- Credit rule:
  - imem_req_valid = !rst && (outstanding + occupancy < DEPTH).
  - Combinational from registered state; it is not a function of imem_req_ready.
- Request accept (req_valid & req_ready): pc <= pc+4 (wraps modulo 2^XLEN); outstanding++.
- Request payload stability:
  - Without redirect, imem_req_addr is held stable while req_valid=1 and req_ready=0.
  - A redirect may change the address of a pending, unaccepted request.
- Response handling (resp_valid):
  - If drop>0: the word is discarded and drop--.
  - Otherwise: {pc_tag, data} is pushed to the FIFO, where pc_tag comes from an in-order PC tag queue written at accept time.
  - In both cases outstanding--.
  - A response while outstanding==0 is ignored; this covers a memory that was not reset with the core.
- Dequeue (id_valid & id_ready): pop the head.
  - Push and pop in the same cycle are legal at any occupancy, including full, where credits guarantee no overflow.
  - Empty FIFO: id_valid=0 and no pop occurs.
- Zero-bubble latency: resp at cycle N appears on id_* at cycle N+1 (registered FIFO).
- Redirect (redirect_valid=1 in cycle N):
  - At edge N: pc <= redirect_pc & ~3 and the FIFO is cleared.
  - drop <= outstanding − (resp_valid?1:0) + (req accepted in N?1:0). In words: every fetch not yet returned, including one accepted in cycle N, is dropped.
  - A response in cycle N is discarded and is not pushed.
  - A dequeue in cycle N still occurs; decode sees the head as consumed, and the flush wins.
  - First request to the new PC may issue at N+1.
  - Redirect has priority over every other update in the same cycle.
  - Back-to-back redirects: the later target wins, and drop accumulates correctly.
- Counter widths: outstanding, drop and occupancy are sized to hold DEPTH. drop ≤ DEPTH by the credit rule.
- Reset mid-operation: all state clears immediately; in-flight responses are handled by the outstanding==0 rule.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN, RESET_PC default and ILEN=32.
  - The opcode localparams RT, IT, LW, SW, BEQ, moved out of the control unit so both blocks share them.
- One natural sub-module: sync_fifo. Parameterised width (XLEN+32) and depth; push/pop/flush/full/empty/count. Instantiated for the instruction FIFO.
- The PC tag queue is a second instance of sync_fifo of width XLEN, with no flush; drop tracking makes a flush unnecessary.

Test Plan:
1. Reset release, imem always ready, 1-cycle response, id_ready=1 → addresses 0x0, 0x4, 0x8… one per cycle; id_pc follows 1 cycle after each response; id_opcode=0x33 for word 0x002081B3.
2. id_ready=0 for 10 cycles → exactly DEPTH=2 requests issued, then imem_req_valid=0. After id_ready=1, fetching resumes at 0x8 with no lost or duplicated word.
3. imem_req_ready low 3 cycles with req_valid=1 → imem_req_addr held at 0x4 all 3 cycles; pc advances only on acceptance.
4. Redirect to 0x103 with 2 fetches outstanding → next request addr 0x100. The 2 stale responses are discarded, and the first id_valid carries id_pc=0x100.
5. Redirect in the same cycle as a request accept and a response → the accepted fetch's later response is dropped, the same-cycle response is not pushed, and drop=outstanding after the edge.
6. Assert rst mid-stream with 2 outstanding; memory returns 2 late responses after release → responses ignored, and the first id_pc is RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core front end.
// Holds the datapath widths, the default reset PC and the base opcodes used
// by both the fetch unit and the control unit.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Base opcodes (instr[6:0]) decoded by the control unit.
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;

  function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   flush           clears all entries; wins over push and pop
//   dout            head entry, zero when empty
//   full, empty     occupancy flags
//   count           number of valid entries
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is carried
  // entirely by the pointers and count, and dout is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Owns the PC, issues word fetches over a valid/ready request channel with
// in-order responses, buffers returned words with their PC and presents them
// to decode. A taken-branch redirect flushes buffered and in-flight fetches.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       fetch request channel (addr = PC)
//   imem_resp_valid/data            in-order fetch responses
//   id_valid/ready                  handshake toward decode
//   id_instr, id_pc, id_opcode      FIFO head word, its PC and its opcode field
//   redirect_valid, redirect_pc     branch redirect (low two bits ignored)
module fetch_unit #(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [rv_pkg::ILEN-1:0] imem_resp_data,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [rv_pkg::ILEN-1:0] id_instr,
  output logic [XLEN-1:0]         id_pc,
  output logic [6:0]              id_opcode,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc
);

  import rv_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     credits_used;
  logic            accept;
  logic            resp_live;
  logic            push_instr;
  logic            pop_instr;
  logic            fifo_empty;
  logic [XLEN-1:0] tag_pc;

  logic            tag_unused_full;
  logic            tag_unused_empty;
  logic [CW-1:0]   tag_unused_count;
  logic            fifo_unused_full;

  // Credits cover both words still in flight and words already buffered, so
  // the instruction FIFO can never be asked to take more than it holds.
  assign credits_used   = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = !rst && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a fetch issued before reset.
  assign resp_live  = imem_resp_valid && (outstanding != '0);
  assign push_instr = resp_live && (drop == '0) && !redirect_valid;
  assign pop_instr  = !fifo_empty && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp_live);
      if (redirect_valid) begin
        pc   <= {redirect_pc[XLEN-1:2], 2'b00};
        // Everything not yet returned after this edge is stale, including a
        // fetch accepted in this very cycle.
        drop <= outstanding + CW'(accept) - CW'(resp_live);
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        if (resp_live && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  // PC tags in request order; responses pop them one for one, so stale
  // entries drain naturally alongside the drop count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (resp_live),
    .flush (1'b0),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tag_unused_full),
    .empty (tag_unused_empty),
    .count (tag_unused_count)
  );

  sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_instr),
    .pop   (pop_instr),
    .flush (redirect_valid),
    .din   ({tag_pc, imem_resp_data}),
    .dout  ({id_pc, id_instr}),
    .full  (fifo_unused_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign id_valid  = !fifo_empty;
  assign id_opcode = opcode_of(id_instr);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  import rv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_opcode       (id_opcode),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: each fetch is a record that is either live or stale;
  // decode sees a plain queue of {pc, word}.
  typedef struct { logic [31:0] pc; bit stale; } fetch_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  fetch_t      inflight[$];
  entry_t      fq[$];
  logic [31:0] m_pc;

  // Memory side: accepted requests with the cycle their response is due.
  mreq_t mq[$];
  int    orphans;
  int    cyc;

  int          p_rdy, p_idr, p_redir, lat_lo, lat_hi;
  bit          force_redir;
  logic [31:0] force_pc;
  int          acc_count;
  bit          op_checked;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0]  ops [5];
    logic [31:0] w;
    int          idx;
    ops[0] = RT; ops[1] = IT; ops[2] = LW; ops[3] = SW; ops[4] = BEQ;
    if (a == 32'h0) return 32'h002081B3;
    w   = (a * 32'h9E3779B1) ^ 32'hC3A5_0F00;
    idx = int'(a[4:2]) % 5;
    return {w[31:7], ops[idx]};
  endfunction

  task automatic set_knobs(input int rdy, input int idr, input int redir, input int lo, input int hi);
    p_rdy = rdy; p_idr = idr; p_redir = redir; lat_lo = lo; lat_hi = hi;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic cycle();
    bit          acc, resp, redir, exp_rv;
    logic [31:0] rpc;
    fetch_t      f;
    imem_req_ready = (orphans == 0) && ($urandom_range(99) < p_rdy);
    id_ready       = ($urandom_range(99) < p_idr);
    redir          = force_redir || ($urandom_range(99) < p_redir);
    rpc            = force_redir ? force_pc : $urandom;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp           = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_rv = (inflight.size() + fq.size()) < DEPTH;
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("id_valid", id_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      check("id_pc", id_pc, fq[0].pc);
      check("id_instr", id_instr, fq[0].instr);
      check("id_opcode", id_opcode, fq[0].instr[6:0]);
      if (!op_checked && fq[0].pc == 32'h0) begin
        check("opcode_rtype", id_opcode, 7'h33);
        op_checked = 1'b1;
      end
    end
    acc = exp_rv && imem_req_ready;
    if (imem_req_valid && imem_req_ready) acc_count++;
    @(posedge clk);
    cyc++;
    if (resp) begin
      void'(mq.pop_front());
      if (orphans > 0) orphans--;
    end
    if (acc) mq.push_back('{m_pc, cyc + int'($urandom_range(lat_hi, lat_lo)) - 1});
    if (fq.size() > 0 && id_ready) void'(fq.pop_front());
    if (resp && inflight.size() > 0) begin
      f = inflight.pop_front();
      if (!f.stale && !redir) fq.push_back('{f.pc, mem_word(f.pc)});
    end
    if (acc) begin
      inflight.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fq.delete();
      m_pc = rpc & ~32'h3;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_opcode", id_opcode, 7'h0);
    inflight.delete();
    fq.delete();
    m_pc    = RST_PC;
    orphans = mq.size();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_first_pc(input string tag, input logic [31:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (id_valid) begin
        check(tag, id_pc, exp);
        got = 1'b1;
        break;
      end
      cycle();
    end
    if (!got) check({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic drain();
    set_knobs(0, 100, 0, 1, 1);
    repeat (8) cycle();
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    force_redir = 1'b0; force_pc = '0; cyc = 0; orphans = 0;
    acc_count = 0; op_checked = 1'b0; m_pc = RST_PC;
    @(negedge clk);
    do_reset();

    // Streaming with an always-ready memory and one-cycle responses.
    set_knobs(100, 100, 0, 1, 1);
    repeat (12) cycle();

    // Decode stalled: only DEPTH fetches may issue.
    drain();
    acc_count = 0;
    set_knobs(100, 0, 0, 1, 1);
    repeat (10) cycle();
    check("stall_req_count", acc_count, DEPTH);
    set_knobs(100, 100, 0, 1, 1);
    repeat (10) cycle();

    // Memory not ready: address holds until acceptance.
    set_knobs(0, 100, 0, 1, 1);
    repeat (3) cycle();
    set_knobs(100, 100, 0, 1, 1);
    repeat (4) cycle();

    // Redirect with two fetches in flight.
    drain();
    set_knobs(100, 100, 0, 6, 6);
    repeat (2) cycle();
    check("redir_outstanding", inflight.size(), 2);
    force_redir = 1'b1; force_pc = 32'h103;
    cycle();
    force_redir = 1'b0;
    set_knobs(100, 100, 0, 1, 1);
    wait_first_pc("redirect_first_pc", 32'h100);

    // Redirect coinciding with a request accept and a response.
    set_knobs(100, 100, 0, 1, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if ((inflight.size() + fq.size() < DEPTH) && mq.size() > 0 && mq[0].due <= cyc) begin
        force_redir = 1'b1; force_pc = 32'h0000_0204; found = 1'b1;
      end
      cycle();
      force_redir = 1'b0;
    end
    check("redir_acc_resp_found", found, 1'b1);
    wait_first_pc("redir_same_cycle_first_pc", 32'h204);

    // Reset with two fetches in flight; their late responses must be ignored.
    drain();
    set_knobs(100, 100, 0, 5, 5);
    repeat (2) cycle();
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    wait_first_pc("reset_first_pc", RST_PC);

    // Random traffic.
    set_knobs(70, 60, 5, 1, 4);
    repeat (1500) cycle();
    set_knobs(90, 80, 15, 1, 3);
    repeat (800) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
